image_row_streamer: RTL and testbench
=====================================

// Module: image_row_streamer
// PURPOSE
//  Transmit side of the 7-bit row bus used by the image reader. Captures a full
//  ROWS x COLS binary image in one cycle and emits it one row per accepted beat.
//  Row 0 comes first and is image_in MSBs, so a reader that does
//  (img<<COLS)|row rebuilds an identical vector.
//  Sits between the image source (test ROM / host loader) and the accelerator's reader.
// PARAMETERS
//  ROWS  28  rows per image (beats per frame)
//  COLS  7   bits per row (row bus width)
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          async, active-high reset
//  start        in   1          request: capture image_in and begin a frame
//  image_in     in   ROWS*COLS  image; row r = image_in[(ROWS-r)*COLS-1 -: COLS]
//  row_ready    in   1          sink accepts current beat (tie 1 for free-running reader)
//  row_data     out  COLS       current row; 0 when row_valid=0
//  row_valid    out  1          row_data valid
//  row_first    out  1          high with row_valid on row 0
//  row_last     out  1          high with row_valid on row ROWS-1
//  busy         out  1          frame in progress (SEND or DONE)
//  frame_done   out  1          one-cycle pulse after last row accepted
// BEHAVIOUR
//  - Single clock clk; reset is asynchronous, active-high.
//  - Reset (any time, incl. mid-frame): state=IDLE, row count=0, shift reg=0.
//    All outputs 0. The frame in progress is dropped, with no done pulse.
//  - States: IDLE -> SEND -> DONE -> IDLE.
//  - IDLE: start=1 at edge N loads image_in into the shift reg, cnt=0, goes to SEND.
//    row_valid=1 with row 0 from cycle N+1 (1-cycle latency). start=0: stay.
//  - SEND: row_data = shift reg top COLS bits; row_valid=1.
//    Beat accepted when row_valid&row_ready at the edge: shift reg <<= COLS
//    (zero fill), cnt += 1.
//    row_ready=0: hold row_data/flags stable (no drop, no repeat).
//    row_first = (cnt==0); row_last = (cnt==ROWS-1); both combinational from registered cnt.
//    Accepted beat with cnt==ROWS-1: go to DONE; row_valid=0 next cycle.
//  - DONE: frame_done=1 for exactly one cycle, busy=1, then IDLE.
//  - start while busy is ignored. It is not queued, and image_in is not resampled.
//    start held high in IDLE after DONE starts the next frame: frames are
//    back-to-back with 1 idle cycle gap (DONE) + 1 load cycle.
//  - With row_ready=1, a frame takes ROWS+2 cycles from start edge to frame_done
//    (28 beats on N+1..N+28, frame_done at N+29).
//  - Counter width $clog2(ROWS); never counts past ROWS-1 (no wrap).
//  - busy = (state!=IDLE). Outputs are registered or decoded from registered
//    state only; no input-to-output combinational path except none (row_ready
//    affects only the next state).
// STRUCTURE
//  - Shared package/header: ROWS=28, COLS=7, IMG_BITS=ROWS*COLS, state encodings
//    (IDLE/SEND/DONE as 2-bit localparams). The reader consumes the same constants.
//  - Single module: FSM + counter + shift register. No sub-module is warranted.
// TESTING
//  1 Reset: assert reset mid-SEND (cnt=10) -> all outputs 0 asynchronously;
//    after release, idle with no frame_done.
//  2 Free-run: row_ready=1, image_in={28{7'h55}} ^ ascending row index ->
//    28 beats on consecutive cycles, row 0 first with row_first=1, row 27 with
//    row_last=1, frame_done at start+29.
//  3 Loopback: connect to image reader (reset_n released on start cycle) ->
//    reader image_data == image_in, image_ready set.
//  4 Backpressure: row_ready toggles 1,0,0,1... -> each row appears exactly once,
//    in order; row_data is stable while stalled; frame_done only after the 28th accept.
//  5 Start while busy: pulse start with a different image at beat 5 ->
//    output frame unchanged; no second frame.
//  6 Back-to-back: start held high 70 cycles -> two full frames, each ending in a
//    frame_done pulse; second row_valid rises 2 cycles after first frame_done... per FSM.

Source files
------------

// File: rtl/image_row_streamer_pkg.sv
// Shared constants and state encoding for the 7-bit image row bus.
// The matching reader imports the same package.
package image_row_streamer_pkg;

  localparam int ROWS     = 28;
  localparam int COLS     = 7;
  localparam int IMG_BITS = ROWS * COLS;
  localparam int CNT_W    = $clog2(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/image_row_streamer_if.sv
// Row bus between the streamer (master) and the image reader (slave).
interface image_row_streamer_if;
  import image_row_streamer_pkg::*;

  logic [COLS-1:0] data;
  logic            valid;
  logic            first;
  logic            last;
  logic            ready;

  modport master (output data, valid, first, last, input ready);
  modport slave  (input data, valid, first, last, output ready);

endinterface

// File: rtl/image_row_streamer.sv
// Captures a full binary image on start and sends it one row per accepted beat,
// row 0 (image MSBs) first. All outputs decode from registered state only.
module image_row_streamer
  import image_row_streamer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IMG_BITS-1:0]   image_in,
  image_row_streamer_if.master  row,
  output logic                  busy,
  output logic                  frame_done
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IMG_BITS-1:0] shreg;

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= image_in;
            cnt   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (row.ready) begin
            shreg <= shreg << COLS;
            // Counter parks on the last row instead of wrapping.
            if (cnt == LAST_ROW) begin
              state <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign row.valid  = (state == ST_SEND);
  assign row.data   = row.valid ? shreg[IMG_BITS-1 -: COLS] : '0;
  assign row.first  = row.valid && (cnt == '0);
  assign row.last   = row.valid && (cnt == LAST_ROW);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_image_row_streamer.sv
// Directed bench for image_row_streamer: table-driven backpressure prefix plus
// hand-written sequences for reset, free-run, start-while-busy and back-to-back.
module tb_image_row_streamer;
  import image_row_streamer_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [IMG_BITS-1:0] image_in;
  logic                busy;
  logic                frame_done;

  image_row_streamer_if rb();

  image_row_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .image_in   (image_in),
    .row        (rb.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic            ready;
    logic            valid;
    logic [COLS-1:0] data;
    logic            first;
    logic            last;
  } vec_t;

  vec_t tv [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COLS-1:0] row_of(input logic [IMG_BITS-1:0] img, input int r);
    logic [IMG_BITS-1:0] s;
    s = img >> ((ROWS - 1 - r) * COLS);
    return s[COLS-1:0];
  endfunction

  function automatic logic [IMG_BITS-1:0] make_img(input logic [COLS-1:0] base, input int mul);
    logic [IMG_BITS-1:0] img;
    img = '0;
    for (int r = 0; r < ROWS; r++) img = (img << COLS) | IMG_BITS'(base ^ COLS'(r * mul));
    return img;
  endfunction

  function automatic logic [11:0] outs();
    return {rb.valid, rb.first, rb.last, busy, frame_done, rb.data};
  endfunction

  task automatic check_beat(input string tag, input logic [IMG_BITS-1:0] img, input int r);
    check($sformatf("%s_data_r%0d", tag, r), 32'(rb.data), 32'(row_of(img, r)));
    check($sformatf("%s_flags_r%0d", tag, r), {28'd0, rb.valid, rb.first, rb.last, frame_done},
          {28'd0, 1'b1, (r == 0), (r == ROWS - 1), 1'b0});
  endtask

  logic [IMG_BITS-1:0] img_a, img_b, img_c, rebuilt;
  int accepts, n_done, n_valid, done1, rise1;
  bit seen_done, prev_valid;

  initial begin
    img_a = make_img(7'h55, 1);
    img_b = make_img(7'h2A, 3);
    img_c = {ROWS{7'h7F}};

    tv[0] = '{1'b0, 1'b1, 7'h55, 1'b1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 7'h55, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 7'h54, 1'b0, 1'b0};
    tv[3] = '{1'b0, 1'b1, 7'h54, 1'b0, 1'b0};
    tv[4] = '{1'b1, 1'b1, 7'h54, 1'b0, 1'b0};
    tv[5] = '{1'b1, 1'b1, 7'h57, 1'b0, 1'b0};
    tv[6] = '{1'b0, 1'b1, 7'h56, 1'b0, 1'b0};
    tv[7] = '{1'b1, 1'b1, 7'h56, 1'b0, 1'b0};

    // Power-on reset
    reset = 1'b1; start = 1'b0; image_in = '0; rb.ready = 1'b1;
    repeat (3) tick;
    check("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;
    tick;
    check("idle_outputs", 32'(outs()), 32'd0);

    // Free-running frame
    image_in = img_a; start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      check_beat("free", img_a, r);
      tick;
    end
    check("free_done", {30'd0, frame_done, busy}, 32'h3);
    check("free_valid_off", 32'(rb.valid), 32'd0);
    tick;
    check("free_idle", 32'(outs()), 32'd0);

    // Backpressure: table prefix then 1,0,0 pattern with loopback rebuild
    image_in = img_a; start = 1'b1;
    tick;
    start = 1'b0;
    rebuilt = '0; accepts = 0;
    for (int i = 0; i < 8; i++) begin
      rb.ready = tv[i].ready;
      check($sformatf("tv%0d", i), {24'd0, rb.valid, rb.data},
            {24'd0, tv[i].valid, tv[i].data});
      check($sformatf("tv%0d_flags", i), {30'd0, rb.first, rb.last},
            {30'd0, tv[i].first, tv[i].last});
      if (rb.ready && rb.valid) begin
        rebuilt = (rebuilt << COLS) | IMG_BITS'(rb.data);
        accepts++;
      end
      tick;
    end
    seen_done = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      rb.ready = (c % 3 == 0);
      if (frame_done) begin
        check("bp_done_after_last", 32'(accepts), 32'(ROWS));
        seen_done = 1'b1;
      end else if (rb.valid) begin
        if (accepts >= ROWS) check("bp_extra_beat", 32'(accepts), 32'(ROWS - 1));
        else check($sformatf("bp_row%0d", accepts), 32'(rb.data), 32'(row_of(img_a, accepts)));
        if (rb.ready) begin
          rebuilt = (rebuilt << COLS) | IMG_BITS'(rb.data);
          accepts++;
        end
      end
      tick;
    end
    if (!seen_done) check("bp_timeout", 32'd0, 32'd1);
    check("bp_loopback", 32'(rebuilt == img_a), 32'd1);
    rb.ready = 1'b1;
    tick;

    // Start while busy: new start and image at beat 5 are ignored
    image_in = img_b; start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 5) begin image_in = img_c; start = 1'b1; end
      check_beat("busy", img_b, r);
      tick;
      if (r == 5) start = 1'b0;
    end
    check("busy_done", 32'(frame_done), 32'd1);
    n_valid = 0;
    for (int c = 0; c < 35; c++) begin
      tick;
      if (rb.valid || frame_done) n_valid++;
    end
    check("busy_no_second", 32'(n_valid), 32'd0);

    // Back-to-back with start held high
    image_in = img_a; start = 1'b1;
    tick;
    n_done = 0; done1 = -1; rise1 = -1; prev_valid = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (frame_done) begin
        n_done++;
        if (done1 < 0) done1 = c;
      end
      if (rb.valid && !prev_valid && done1 >= 0 && rise1 < 0) rise1 = c;
      prev_valid = rb.valid;
      tick;
    end
    start = 1'b0;
    check("b2b_done_count", 32'(n_done), 32'd2);
    check("b2b_first_done", 32'(done1), 32'd28);
    check("b2b_gap", 32'(rise1 - done1), 32'd2);
    seen_done = 1'b0;
    for (int c = 0; c < 60 && busy; c++) tick;
    check("b2b_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-frame at cnt=10
    image_in = img_a; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    check_beat("rst", img_a, 10);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    n_done = 0; n_valid = 0;
    for (int c = 0; c < 35; c++) begin
      tick;
      if (frame_done) n_done++;
      if (rb.valid) n_valid++;
    end
    check("reset_no_done", 32'(n_done), 32'd0);
    check("reset_no_valid", 32'(n_valid), 32'd0);
    check("reset_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
